// File: rtl/operand_stage_pkg.sv
// Shared types and constants for the operand pipeline stage.
package operand_stage_pkg;

    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } opState_t;

endpackage

// File: rtl/operand_stage_stall_ctr.sv
// Saturating back-pressure counter; cleared by reset only.
module operand_stage_stall_ctr
    import operand_stage_pkg::*;
#(
    parameter int unsigned W = STALL_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/operand_stage.sv
// ALU operand stage: CHANNELS x WIDTH bundle register with two-entry skid buffer and flush.
// Optional stall_count port enabled by OPSTAGE_STALL_CNT_EN.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef OPSTAGE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]    stall_count
`endif
);

    localparam int unsigned BUNDLE_W = CHANNELS * WIDTH;

    opState_t            state;
    opState_t            nextState;
    logic [BUNDLE_W-1:0] mainQ;
    logic [BUNDLE_W-1:0] skidQ;
    logic                outValidQ;
    logic                inReadyQ;
    logic                loadMain;
    logic                mainFromSkid;
    logic                loadSkid;

    // Next-state and register-load decode; flush discards everything held or presented.
    always_comb begin
        nextState    = state;
        loadMain     = 1'b0;
        mainFromSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            nextState = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        loadMain  = 1'b1;
                        nextState = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            loadMain = 1'b1;
                        end else begin
                            nextState = ST_EMPTY;
                        end
                    end else if (in_valid) begin
                        loadSkid  = 1'b1;
                        nextState = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        loadMain     = 1'b1;
                        mainFromSkid = 1'b1;
                        nextState    = ST_FULL;
                    end
                end
                default: nextState = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered from the next state so they are plain flop outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            mainQ     <= '0;
            skidQ     <= '0;
            outValidQ <= 1'b0;
            inReadyQ  <= 1'b1;
        end else begin
            state     <= nextState;
            outValidQ <= (nextState != ST_EMPTY);
            inReadyQ  <= (nextState != ST_SKID);
            if (loadMain) begin
                mainQ <= mainFromSkid ? skidQ : in_data;
            end
            if (loadSkid) begin
                skidQ <= in_data;
            end
        end
    end

    assign out_data  = mainQ;
    assign out_valid = outValidQ;
    assign in_ready  = inReadyQ;

`ifdef OPSTAGE_STALL_CNT_EN
    operand_stage_stall_ctr #(
        .W(STALL_CNT_W)
    ) u_stall_ctr (
        .clk  (clk),
        .reset(reset),
        .inc  (outValidQ & ~out_ready),
        .count(stall_count)
    );
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage (CHANNELS=2, WIDTH=32).
module tb_operand_stage;
    import operand_stage_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned CH = 2;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CH*W-1:0] out_data;
`ifdef OPSTAGE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_count;
`endif

    int nAsserts = 0;
    int nFails   = 0;

    operand_stage #(
        .WIDTH   (W),
        .CHANNELS(CH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef OPSTAGE_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH*W-1:0] bundle(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a, b};
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nAsserts++;
        if (observed !== expected) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = '1;
        out_ready = 1'b0;

        // Reset with garbage presented
        tick(2);
        checkVal("rst_out_valid", 64'(out_valid), 64'd0);
        checkVal("rst_in_ready", 64'(in_ready), 64'd1);
        checkVal("rst_out_data", 64'(out_data), 64'd0);
`ifdef OPSTAGE_STALL_CNT_EN
        checkVal("rst_stall_count", 64'(stall_count), 64'd0);
`endif
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        checkVal("idle_out_valid", 64'(out_valid), 64'd0);

        // Streaming, out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = bundle(32'd1, 32'd2);
        tick();
        checkVal("str0_valid", 64'(out_valid), 64'd1);
        checkVal("str0_data", 64'(out_data), 64'(bundle(32'd1, 32'd2)));
        checkVal("str0_ready", 64'(in_ready), 64'd1);
        in_data = bundle(32'd3, 32'd4);
        tick();
        checkVal("str1_data", 64'(out_data), 64'(bundle(32'd3, 32'd4)));
        checkVal("str1_ready", 64'(in_ready), 64'd1);
        in_data = bundle(32'd5, 32'd6);
        tick();
        checkVal("str2_data", 64'(out_data), 64'(bundle(32'd5, 32'd6)));
        checkVal("str2_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        checkVal("str_drain_valid", 64'(out_valid), 64'd0);

        // Skid under back-pressure
        in_valid = 1'b1;
        in_data  = bundle(32'd1, 32'd2);
        tick();
        out_ready = 1'b0;
        in_data   = bundle(32'd3, 32'd4);
        tick();
        checkVal("skid_in_ready", 64'(in_ready), 64'd0);
        checkVal("skid_hold_data", 64'(out_data), 64'(bundle(32'd1, 32'd2)));
        checkVal("skid_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        checkVal("skid_hold2_data", 64'(out_data), 64'(bundle(32'd1, 32'd2)));
        checkVal("skid_hold2_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        checkVal("skid_second_data", 64'(out_data), 64'(bundle(32'd3, 32'd4)));
        checkVal("skid_second_valid", 64'(out_valid), 64'd1);
        checkVal("skid_ready_back", 64'(in_ready), 64'd1);
        tick();
        checkVal("skid_drain_valid", 64'(out_valid), 64'd0);

        // Flush from SKID with a bundle presented
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = bundle(32'd1, 32'd2);
        tick();
        in_data = bundle(32'd3, 32'd4);
        tick();
        checkVal("pre_flush_ready", 64'(in_ready), 64'd0);
        flush   = 1'b1;
        in_data = bundle(32'd9, 32'd9);
        tick();
        checkVal("flush_valid", 64'(out_valid), 64'd0);
        checkVal("flush_ready", 64'(in_ready), 64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("post_flush_valid", 64'(out_valid), 64'd0);
        end

        // Reset beats flush with data held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = bundle(32'd7, 32'd8);
        tick();
        checkVal("hold78_data", 64'(out_data), 64'(bundle(32'd7, 32'd8)));
        in_valid = 1'b0;
        reset    = 1'b1;
        flush    = 1'b1;
        tick();
        checkVal("rstflush_data", 64'(out_data), 64'd0);
        checkVal("rstflush_valid", 64'(out_valid), 64'd0);
        checkVal("rstflush_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        flush = 1'b0;

`ifdef OPSTAGE_STALL_CNT_EN
        // Saturating stall counter
        checkVal("stall_after_rst", 64'(stall_count), 64'd0);
        in_valid = 1'b1;
        in_data  = bundle(32'd11, 32'd12);
        tick();
        in_valid = 1'b0;
        checkVal("stall_first", 64'(stall_count), 64'd0);
        tick(10);
        checkVal("stall_ten", 64'(stall_count), 64'd10);
        tick(69990);
        checkVal("stall_sat", 64'(stall_count), 64'hFFFF);
        tick(5);
        checkVal("stall_sat_hold", 64'(stall_count), 64'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkVal("stall_flush_keep", 64'(stall_count), 64'hFFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkVal("stall_rst_clear", 64'(stall_count), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
